// File: rtl/controller_pkg.sv
// Shared definitions for the console-facing controller responder and the
// console-side controller interface.
package controller_pkg;

    // Frame protocol states: wait for latch, capture buttons, shift out, finished.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    // Button bits in one frame on a standard pad.
    localparam int CTRL_NUM_BUTTONS = 8;

endpackage : controller_pkg

// File: rtl/sync_edge_m.sv
// Multi-flop synchronizer for an asynchronous pin, followed by one history
// flop so the synchronized level can be edge-detected.
module sync_edge_m #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_B,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Shift the pin through the synchronizer chain and remember the last level.
    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  o_level & ~r_hist;
    assign o_fall  = ~o_level &  r_hist;

endmodule : sync_edge_m

// File: rtl/controller_responder_m.sv
// Controller-side responder: captures buttons on console latch and shifts
// them out, A first, on each console clock edge as active-low serial data.
module controller_responder_m
    import controller_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int NUM_BUTTONS  = CTRL_NUM_BUTTONS,
    parameter bit FILL_PRESSED = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_B,
    input  logic                   controller_clk_in,
    input  logic                   controller_latch_in,
    input  logic [NUM_BUTTONS-1:0] buttons_in,
    output logic                   data_out_B,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int             CW       = $clog2(NUM_BUTTONS + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(NUM_BUTTONS - 1);

    ctrl_state_t            r_state, w_state_nxt;
    logic [NUM_BUTTONS-1:0] r_shreg, w_shreg_nxt;
    logic [CW-1:0]          r_cnt,   w_cnt_nxt;
    logic                   r_dout,  w_dout_nxt;
    logic                   r_frame_done, w_frame_done_nxt;

    logic w_latch_lvl, w_latch_rise, w_latch_fall;
    logic w_clk_lvl,   w_clk_rise,   w_clk_fall;

    sync_edge_m #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk     (clk),
        .rst_B   (rst_B),
        .i_async (controller_latch_in),
        .o_level (w_latch_lvl),
        .o_rise  (w_latch_rise),
        .o_fall  (w_latch_fall)
    );

    sync_edge_m #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk     (clk),
        .rst_B   (rst_B),
        .i_async (controller_clk_in),
        .o_level (w_clk_lvl),
        .o_rise  (w_clk_rise),
        .o_fall  (w_clk_fall)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state plus datapath updates; latch level overrides every state,
    // so a clock edge seen in the same synchronized cycle is dropped.
    always_comb begin
        w_state_nxt      = r_state;
        w_shreg_nxt      = r_shreg;
        w_cnt_nxt        = r_cnt;
        w_frame_done_nxt = 1'b0;
        w_dout_nxt       = r_dout;
        if (w_latch_lvl) begin
            w_state_nxt = ST_LATCH;
            w_shreg_nxt = buttons_in;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_LATCH: begin
                    // Falling latch freezes the last captured value.
                    if (w_latch_fall) begin
                        w_state_nxt = ST_SHIFT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_clk_rise) begin
                        w_shreg_nxt = {FILL_PRESSED, r_shreg[NUM_BUTTONS-1:1]};
                        w_cnt_nxt   = r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt      = ST_DONE;
                            w_frame_done_nxt = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        // Serial line follows the state being entered so it updates on the
        // same clk as the shift register.
        case (w_state_nxt)
            ST_IDLE: w_dout_nxt = 1'b1;
            ST_DONE: w_dout_nxt = ~FILL_PRESSED;
            default: w_dout_nxt = ~w_shreg_nxt[0];
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_dout       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_shreg      <= w_shreg_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dout       <= w_dout_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign data_out_B = r_dout;
    assign frame_done = r_frame_done;
    assign busy       = (r_state == ST_LATCH) || (r_state == ST_SHIFT);

endmodule : controller_responder_m

// File: doc/controller_responder_m.md
CONTROLLER_RESPONDER_M -- requirements
Module: controller_responder_m

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in each input synchronizer (minimum 2).
REQ-002 SHALL have parameter NUM_BUTTONS, default 8, number of button bits in one frame.
REQ-003 SHALL have parameter FILL_PRESSED, default 1; 1 = after frame exhaustion, line reads pressed (data_out_B=0), matching an original controller.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_B, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port controller_clk_in, input, 1, console shift clock, asynchronous to clk.
REQ-007 SHALL have port controller_latch_in, input, 1, console latch, asynchronous to clk, active-high.
REQ-008 SHALL have port buttons_in, input, NUM_BUTTONS, live button state, active-high; bit 0 = A, shifted first.
REQ-009 SHALL have port data_out_B, output, 1, serial button data to console, active-low (0 = pressed).
REQ-010 SHALL have port busy, output, 1, high in LATCH or SHIFT states.
REQ-011 SHALL have port frame_done, output, 1, one-clk pulse when the last button bit has been shifted out.

Function
REQ-012 SHALL pass controller_clk_in and controller_latch_in through SYNC_STAGES-deep synchronizers plus one history flop for edge detection.
REQ-013 SHALL implement states IDLE, LATCH, SHIFT, DONE.
REQ-014 IDLE -> LATCH on synchronized latch high; any state -> LATCH on synchronized latch high (latch preempts everything, including a mid-frame abort).
REQ-015 In LATCH, shift register SHALL reload from buttons_in every clk; data_out_B SHALL equal ~buttons_in[0] registered (one clk behind).
REQ-016 LATCH -> SHIFT on synchronized latch falling edge; bit counter cleared to 0; last loaded value frozen.
REQ-017 In SHIFT, each synchronized controller_clk_in rising edge SHALL shift register right by one, fill MSB with FILL_PRESSED, increment counter.
REQ-018 SHIFT -> DONE when counter reaches NUM_BUTTONS; frame_done asserted on that transition's clk only.
REQ-019 In DONE, further clock edges SHALL be ignored; data_out_B = ~FILL_PRESSED; DONE -> IDLE never except via reset; DONE -> LATCH on latch.
REQ-020 In IDLE, data_out_B SHALL be 1.
REQ-021 Clock rising edge coincident with latch high (same synchronized cycle) SHALL be ignored; latch wins.
REQ-022 Clock edges in IDLE or LATCH SHALL not shift or count.
REQ-023 data_out_B SHALL be registered; pin transition to data_out_B update latency SHALL be exactly SYNC_STAGES+1 clk cycles.
REQ-024 Counter width SHALL be $clog2(NUM_BUTTONS+1); counter SHALL saturate at NUM_BUTTONS, never wrap.
REQ-025 clk frequency SHALL be at least 8x controller_clk_in frequency; slower clk is unsupported.

Reset
REQ-026 On rst_B low, asynchronously: state IDLE, shift register 0, counter 0, synchronizer and history flops 0, data_out_B 1, busy 0, frame_done 0.
REQ-027 Reset deassertion mid-frame SHALL restart in IDLE; no partial frame resumed.

Structure
REQ-028 State enum and default NUM_BUTTONS SHALL live in shared package controller_pkg, also used by the console-side controller interface.
REQ-029 Synchronizer-plus-edge-detector SHALL be sub-module sync_edge_m (outputs level, rise, fall), instanced twice.

Verification
REQ-030 buttons_in=8'b0000_0101, latch pulse, 8 clock pulses -> data_out_B sequence 0,1,0,1,1,1,1,1; frame_done one pulse after 8th.
REQ-031 Completed frame then 3 extra clock pulses, FILL_PRESSED=1 -> data_out_B stays 0, counter stays 8, no second frame_done.
REQ-032 Latch reasserted after 4 shifts with buttons_in=8'hFF -> state LATCH, data_out_B=0, next frame starts at bit 0.
REQ-033 Clock edge arriving same synchronized cycle as latch rise -> no shift, counter 0.
REQ-034 rst_B low during SHIFT after 3 bits -> data_out_B=1, busy=0 immediately (asynchronous), IDLE after release.
REQ-035 Latch fall at pin -> first data_out_B change measured exactly SYNC_STAGES+1=3 clk later for a clock edge.
